// File: rtl/l09_pkg.sv
// l09_pkg: shared types, default parameters and the preload clamp helper
// used by the modulo-N down counter.
//   state_t     : COUNT (normal) / EXPIRED (saturating build only)
//   WIDTH_DEF   : default counter width
//   MODULO_DEF  : default count modulus
//   clamp_load  : maps an out-of-range preload value onto modulo-1
package l09_pkg;

  typedef enum logic [0:0] {
    COUNT   = 1'b0,
    EXPIRED = 1'b1
  } state_t;

  localparam int WIDTH_DEF  = 2;
  localparam int MODULO_DEF = 3;

  // Values at or above the modulus would be illegal counts; pin them to the top.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulo);
    if (val >= modulo) begin
      return modulo - 32'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/l09_down_counter.sv
// l09_down_counter: modulo-N down counter with synchronous preload and a
// registered one-cycle borrow pulse on wrap.
// Build option: define L09_DOWN_SATURATE_EN to make the counter stop at 0
// (state EXPIRED) instead of wrapping; a load re-arms it.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   load     : synchronous preload strobe (wins over down)
//   load_val : preload value, clamped to MODULO-1 when >= MODULO
//   down     : decrement enable, sampled each rising edge
//   counter  : current count (registered)
//   zero     : counter == 0, decoded from the register
//   borrow   : registered one-cycle wrap pulse
//   busy     : high while in state COUNT
module l09_down_counter
  import l09_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int MODULO = MODULO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             down,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] counter_r;
  logic [WIDTH-1:0] counter_nxt_s;
  logic             borrow_r;
  logic             borrow_nxt_s;
  logic [WIDTH-1:0] load_clamped_s;

  // The clamp compares the full load_val width before narrowing back.
  assign load_clamped_s = WIDTH'(clamp_load(32'(load_val), 32'(MODULO)));

  // Next-state, next-count and next-borrow decode.
  always_comb begin
    state_nxt_s   = state_r;
    counter_nxt_s = counter_r;
    borrow_nxt_s  = 1'b0;
    case (state_r)
      COUNT: begin
        if (load) begin
          counter_nxt_s = load_clamped_s;
        end else if (down && (counter_r != ZERO_VAL)) begin
          counter_nxt_s = counter_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (down) begin
          borrow_nxt_s  = 1'b1;
`ifdef L09_DOWN_SATURATE_EN
          counter_nxt_s = ZERO_VAL;
          state_nxt_s   = EXPIRED;
`else
          counter_nxt_s = MAX_VAL;
`endif
        end else begin
          counter_nxt_s = counter_r;
        end
      end
      EXPIRED: begin
`ifdef L09_DOWN_SATURATE_EN
        if (load) begin
          counter_nxt_s = load_clamped_s;
          state_nxt_s   = COUNT;
        end else begin
          counter_nxt_s = ZERO_VAL;
        end
`else
        // Unreachable without saturation; recover to the reset condition.
        counter_nxt_s = MAX_VAL;
        state_nxt_s   = COUNT;
`endif
      end
      default: begin
        counter_nxt_s = MAX_VAL;
        state_nxt_s   = COUNT;
      end
    endcase
  end

  // State, count and borrow registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= COUNT;
      counter_r <= MAX_VAL;
      borrow_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      counter_r <= counter_nxt_s;
      borrow_r  <= borrow_nxt_s;
    end
  end

  assign counter = counter_r;
  assign borrow  = borrow_r;
  assign zero    = (counter_r == ZERO_VAL);
  assign busy    = (state_r == COUNT);

endmodule

// File: tb/tb_l09_down_counter.sv
// Self-checking bench for l09_down_counter: one instance at MODULO=3/WIDTH=2
// and one at MODULO=2/WIDTH=1, each tracked by an arithmetic model and
// checked every falling edge, plus directed vectors with literal expectations.
// Honours L09_DOWN_SATURATE_EN the same way the design does.
module tb_l09_down_counter;

  localparam int M1 = 3;
  localparam int M2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       load1 = 1'b0;
  logic [1:0] lv1 = 2'd0;
  logic       down1 = 1'b0;
  logic [1:0] cnt1;
  logic       zero1, bor1, busy1;
  logic       load2 = 1'b0;
  logic [0:0] lv2 = 1'b0;
  logic       down2 = 1'b0;
  logic [0:0] cnt2;
  logic       zero2, bor2, busy2;

  int total = 0;
  int bad   = 0;

  l09_down_counter #(.WIDTH(2), .MODULO(M1)) dut (
    .clk(clk), .rst(rst), .load(load1), .load_val(lv1), .down(down1),
    .counter(cnt1), .zero(zero1), .borrow(bor1), .busy(busy1)
  );

  l09_down_counter #(.WIDTH(1), .MODULO(M2)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .load_val(lv2), .down(down2),
    .counter(cnt2), .zero(zero2), .borrow(bor2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: count down mod N, borrow when leaving 0.
  task automatic model_step(input int mod, input int c_i, input bit e_i,
                            input bit ld, input int lv, input bit dn,
                            output int c_o, output bit b_o, output bit e_o);
    c_o = c_i;
    b_o = 1'b0;
    e_o = e_i;
    if (ld) begin
      c_o = (lv < mod) ? lv : mod - 1;
      e_o = 1'b0;
    end else if (dn && !e_i) begin
      b_o = (c_i == 0);
`ifdef L09_DOWN_SATURATE_EN
      c_o = (c_i == 0) ? 0 : c_i - 1;
      e_o = (c_i == 0);
`else
      c_o = (c_i + mod - 1) % mod;
`endif
    end
  endtask

  int m1_c = M1 - 1;
  bit m1_b = 1'b0, m1_e = 1'b0;
  int m2_c = M2 - 1;
  bit m2_b = 1'b0, m2_e = 1'b0;

  always @(posedge clk or posedge rst) begin : mdl
    int c;
    bit b, e;
    if (rst) begin
      m1_c <= M1 - 1; m1_b <= 1'b0; m1_e <= 1'b0;
      m2_c <= M2 - 1; m2_b <= 1'b0; m2_e <= 1'b0;
    end else begin
      model_step(M1, m1_c, m1_e, load1, int'(lv1), down1, c, b, e);
      m1_c <= c; m1_b <= b; m1_e <= e;
      model_step(M2, m2_c, m2_e, load2, int'(lv2), down2, c, b, e);
      m2_c <= c; m2_b <= b; m2_e <= e;
    end
  end

  // Continuous model comparison on every falling edge.
  always @(negedge clk) begin
    check("m1_counter", int'(cnt1), m1_c);
    check("m1_zero",    int'(zero1), int'(m1_c == 0));
    check("m1_borrow",  int'(bor1), int'(m1_b));
    check("m1_busy",    int'(busy1), int'(!m1_e));
    check("m2_counter", int'(cnt2), m2_c);
    check("m2_zero",    int'(zero2), int'(m2_c == 0));
    check("m2_borrow",  int'(bor2), int'(m2_b));
    check("m2_busy",    int'(busy2), int'(!m2_e));
  end

  // One clock on dut with literal expectations.
  task automatic cyc(input string nm, input bit l, input int lv, input bit d,
                     input int ec, input bit eb, input bit ebusy);
    @(negedge clk);
    load1 = l; lv1 = 2'(lv); down1 = d;
    load2 = 1'b0; down2 = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_cnt"},  int'(cnt1), ec);
    check({nm, "_bor"},  int'(bor1), int'(eb));
    check({nm, "_zero"}, int'(zero1), int'(ec == 0));
    check({nm, "_busy"}, int'(busy1), int'(ebusy));
  endtask

  // One clock on dut2 with literal expectations.
  task automatic cyc2(input string nm, input bit d, input int ec, input bit eb, input bit ebusy);
    @(negedge clk);
    load1 = 1'b0; down1 = 1'b0;
    load2 = 1'b0; down2 = d;
    @(posedge clk);
    #1;
    check({nm, "_cnt"},  int'(cnt2), ec);
    check({nm, "_bor"},  int'(bor2), int'(eb));
    check({nm, "_busy"}, int'(busy2), int'(ebusy));
  endtask

  initial begin
    rst = 1'b1;
    #8;
    check("rst_cnt",  int'(cnt1), 2);
    check("rst_zero", int'(zero1), 0);
    check("rst_bor",  int'(bor1), 0);
    check("rst_busy", int'(busy1), 1);
    #4;
    rst = 1'b0;

`ifdef L09_DOWN_SATURATE_EN
    cyc2("m2_d1", 1'b1, 0, 1'b0, 1'b1);
    cyc2("m2_d2", 1'b1, 0, 1'b1, 1'b0);
    cyc2("m2_d3", 1'b1, 0, 1'b0, 1'b0);
    cyc2("m2_d4", 1'b1, 0, 1'b0, 1'b0);

    cyc("sat_d1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    cyc("sat_d2", 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
    cyc("sat_d3", 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
    cyc("sat_d4", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    cyc("sat_d5", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    cyc("sat_ld2", 1'b1, 2, 1'b1, 2, 1'b0, 1'b1);
`else
    cyc2("m2_d1", 1'b1, 0, 1'b0, 1'b1);
    cyc2("m2_d2", 1'b1, 1, 1'b1, 1'b1);
    cyc2("m2_d3", 1'b1, 0, 1'b0, 1'b1);
    cyc2("m2_d4", 1'b1, 1, 1'b1, 1'b1);

    cyc("held_d1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    cyc("held_d2", 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
    cyc("held_d3", 1'b0, 0, 1'b1, 2, 1'b1, 1'b1);
    cyc("held_d4", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
`endif

    cyc("ld_wins", 1'b1, 1, 1'b1, 1, 1'b0, 1'b1);
    cyc("ld_clamp", 1'b1, 3, 1'b0, 2, 1'b0, 1'b1);
    cyc("tog_1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    cyc("tog_0", 1'b0, 0, 1'b0, 1, 1'b0, 1'b1);
    cyc("tog_1b", 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
    cyc("tog_0b", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

`ifdef L09_DOWN_SATURATE_EN
    cyc("at_zero", 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
`else
    cyc("at_zero", 1'b0, 0, 1'b1, 2, 1'b1, 1'b1);
`endif

    // Asynchronous reset pulse inside a clock period.
    @(negedge clk);
    load1 = 1'b0; down1 = 1'b0; down2 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt",   int'(cnt1), 2);
    check("arst_bor",   int'(bor1), 0);
    check("arst_busy",  int'(busy1), 1);
    check("arst_cnt2",  int'(cnt2), 1);
    check("arst_busy2", int'(busy2), 1);
    #1;
    rst = 1'b0;

    cyc("resume", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);

    @(negedge clk);
    down1 = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
